// File: rtl/match_sequencer.sv
// Match sequencer: walks a two-team game through serve, play, goal pause and game over,
// keeping score and gating ball/player movement.
module match_sequencer #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_CYCLES = 50000000,
    parameter int PAUSE_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_button,
    input  logic       score_to_team1,
    input  logic       score_to_team2,
    output logic       ball_reset,
    output logic       ball_enable,
    output logic       players_enable,
    output logic [3:0] team1_points,
    output logic [3:0] team2_points,
    output logic [1:0] winner,
    output logic [2:0] state
);

    // state      | meaning
    // IDLE       | waiting for start, everything disabled
    // SERVE      | ball re-centred, players may move, ball held
    // PLAY       | ball and players live, goals scored here
    // GOAL_PAUSE | everything frozen after a goal
    // GAME_OVER  | winner shown, waiting for start to replay

    localparam int MAX_CYCLES = (SERVE_CYCLES > PAUSE_CYCLES) ? SERVE_CYCLES : PAUSE_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_CYCLES - 1);
    localparam logic [CW-1:0] PAUSE_LAST = CW'(PAUSE_CYCLES - 1);
    localparam logic [3:0]    WIN_PTS    = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    team1_q, team1_d;
    logic [3:0]    team2_q, team2_d;
    logic [1:0]    winner_q, winner_d;
    logic          ball_reset_q, ball_enable_q, players_enable_q;

    logic armed_q, start_q, goal1_q, goal2_q;
    logic start_edge, goal1_edge, goal2_edge;

    // Edges are masked for the first clock after reset so a level already high at release is not an edge.
    assign start_edge = armed_q & start_button   & ~start_q;
    assign goal1_edge = armed_q & score_to_team1 & ~goal1_q;
    assign goal2_edge = armed_q & score_to_team2 & ~goal2_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        team1_d  = team1_q;
        team2_d  = team2_q;
        winner_d = winner_q;

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d = ST_SERVE;
                    team1_d = 4'd0;
                    team2_d = 4'd0;
                end
            end
            ST_SERVE: begin
                if (cnt_q == SERVE_LAST) begin
                    state_d = ST_PLAY;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_PLAY: begin
                if (goal1_edge && goal2_edge) begin
                    state_d = ST_SERVE;
                end else if (goal1_edge) begin
                    state_d = ST_PAUSE;
                    if (team1_q < WIN_PTS) begin
                        team1_d = team1_q + 4'd1;
                    end
                end else if (goal2_edge) begin
                    state_d = ST_PAUSE;
                    if (team2_q < WIN_PTS) begin
                        team2_d = team2_q + 4'd1;
                    end
                end
            end
            ST_PAUSE: begin
                if (cnt_q == PAUSE_LAST) begin
                    if (team1_q == WIN_PTS) begin
                        state_d  = ST_OVER;
                        winner_d = 2'b01;
                    end else if (team2_q == WIN_PTS) begin
                        state_d  = ST_OVER;
                        winner_d = 2'b10;
                    end else begin
                        state_d = ST_SERVE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_OVER: begin
                if (start_edge) begin
                    state_d  = ST_SERVE;
                    team1_d  = 4'd0;
                    team2_d  = 4'd0;
                    winner_d = 2'b00;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // One shared timer, restarted on every state entry.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            team1_q          <= 4'd0;
            team2_q          <= 4'd0;
            winner_q         <= 2'b00;
            ball_reset_q     <= 1'b0;
            ball_enable_q    <= 1'b0;
            players_enable_q <= 1'b0;
            armed_q          <= 1'b0;
            start_q          <= 1'b0;
            goal1_q          <= 1'b0;
            goal2_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            team1_q          <= team1_d;
            team2_q          <= team2_d;
            winner_q         <= winner_d;
            ball_reset_q     <= (state_d == ST_SERVE) && (state_q != ST_SERVE);
            ball_enable_q    <= (state_d == ST_PLAY);
            players_enable_q <= (state_d == ST_SERVE) || (state_d == ST_PLAY);
            armed_q          <= 1'b1;
            start_q          <= start_button;
            goal1_q          <= score_to_team1;
            goal2_q          <= score_to_team2;
        end
    end

    assign ball_reset     = ball_reset_q;
    assign ball_enable    = ball_enable_q;
    assign players_enable = players_enable_q;
    assign team1_points   = team1_q;
    assign team2_points   = team2_q;
    assign winner         = winner_q;
    assign state          = state_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Bench for match_sequencer: fixed vector table, reset corner sequence, then random play
// compared against a countdown-based reference model.
module tb_match_sequencer;

    localparam int W  = 2;
    localparam int SC = 3;
    localparam int PC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_button = 1'b0;
    logic       score_to_team1 = 1'b0;
    logic       score_to_team2 = 1'b0;
    logic       ball_reset, ball_enable, players_enable;
    logic [3:0] team1_points, team2_points;
    logic [1:0] winner;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    match_sequencer #(.WIN_SCORE(W), .SERVE_CYCLES(SC), .PAUSE_CYCLES(PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_button   (start_button),
        .score_to_team1 (score_to_team1),
        .score_to_team2 (score_to_team2),
        .ball_reset     (ball_reset),
        .ball_enable    (ball_enable),
        .players_enable (players_enable),
        .team1_points   (team1_points),
        .team2_points   (team2_points),
        .winner         (winner),
        .state          (state)
    );

    always #5 clk = ~clk;

    // Reference model: phase number, cycles remaining in the timed phase, scores.
    int m_st, m_p1, m_p2, m_w, m_rem;
    bit m_br, m_armed, m_ps, m_pg1, m_pg2;

    task automatic model_reset();
        m_st = 0; m_p1 = 0; m_p2 = 0; m_w = 0; m_rem = 0;
        m_br = 0; m_armed = 0; m_ps = 0; m_pg1 = 0; m_pg2 = 0;
    endtask

    task automatic model_step(input logic s, input logic g1, input logic g2);
        bit se, e1, e2;
        se = m_armed && s && !m_ps;
        e1 = m_armed && g1 && !m_pg1;
        e2 = m_armed && g2 && !m_pg2;
        m_armed = 1; m_ps = s; m_pg1 = g1; m_pg2 = g2;
        m_br = 0;
        case (m_st)
            0: if (se) begin
                m_p1 = 0; m_p2 = 0;
                m_st = 1; m_rem = SC; m_br = 1;
            end
            1: begin
                m_rem--;
                if (m_rem == 0) m_st = 2;
            end
            2: if (e1 && e2) begin
                m_st = 1; m_rem = SC; m_br = 1;
            end else if (e1) begin
                if (m_p1 < W) m_p1++;
                m_st = 3; m_rem = PC;
            end else if (e2) begin
                if (m_p2 < W) m_p2++;
                m_st = 3; m_rem = PC;
            end
            3: begin
                m_rem--;
                if (m_rem == 0) begin
                    if (m_p1 == W) begin m_st = 4; m_w = 1; end
                    else if (m_p2 == W) begin m_st = 4; m_w = 2; end
                    else begin m_st = 1; m_rem = SC; m_br = 1; end
                end
            end
            default: if (se) begin
                m_p1 = 0; m_p2 = 0; m_w = 0;
                m_st = 1; m_rem = SC; m_br = 1;
            end
        endcase
    endtask

    function automatic logic [15:0] model_vec();
        return {3'(m_st), 4'(m_p1), 4'(m_p2), 2'(m_w), m_br,
                logic'(m_st == 2), logic'(m_st == 1 || m_st == 2)};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {state, team1_points, team2_points, winner, ball_reset, ball_enable, players_enable};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h (st/p1/p2/w/br/be/pe) required %h", name, act, exp);
        end
    endtask

    task automatic tick(input logic s, input logic g1, input logic g2);
        @(negedge clk);
        rst_n = 1'b1;
        start_button = s;
        score_to_team1 = g1;
        score_to_team2 = g2;
        @(posedge clk);
        model_step(s, g1, g2);
        #1;
    endtask

    // Called just after a sampling point; asserts reset mid-cycle and checks it takes effect at once.
    task automatic assert_reset();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_reset", dut_vec(), 16'h0000);
        repeat (2) @(posedge clk);
    endtask

    typedef struct {
        logic       s, g1, g2;
        logic [2:0] st;
        logic [3:0] p1, p2;
        logic [1:0] w;
        logic       br;
    } vec_t;

    function automatic vec_t v(input logic s, input logic g1, input logic g2, input logic [2:0] st,
                               input logic [3:0] p1, input logic [3:0] p2, input logic [1:0] w,
                               input logic br);
        vec_t t;
        t.s = s; t.g1 = g1; t.g2 = g2; t.st = st; t.p1 = p1; t.p2 = p2; t.w = w; t.br = br;
        return t;
    endfunction

    function automatic logic [15:0] exp_of(input vec_t t);
        return {t.st, t.p1, t.p2, t.w, t.br, logic'(t.st == 3'd2),
                logic'(t.st == 3'd1 || t.st == 3'd2)};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        logic rs, rg1, rg2;

        //                s  g1 g2  st p1 p2 w  br
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0));  // release
        tbl.push_back(v(1, 0, 0, 1, 0, 0, 0, 1));  // start -> serve
        tbl.push_back(v(1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 2, 0, 0, 0, 0));  // play
        tbl.push_back(v(0, 1, 0, 3, 1, 0, 0, 0));  // team1 goal, held
        tbl.push_back(v(0, 1, 0, 3, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 3, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 3, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 1, 0, 0, 1));
        tbl.push_back(v(0, 1, 0, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 2, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 2, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 2, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 2, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 3, 1, 1, 0, 0));  // team2 goal
        tbl.push_back(v(0, 0, 0, 3, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 3, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 3, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 1, 1, 0, 1));
        tbl.push_back(v(0, 1, 0, 1, 1, 1, 0, 0));  // goal edge in serve ignored
        tbl.push_back(v(0, 0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 2, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 1, 3, 1, 2, 0, 0));  // team2 reaches win score
        tbl.push_back(v(0, 1, 0, 3, 1, 2, 0, 0));  // goal edge in pause ignored
        tbl.push_back(v(0, 0, 0, 3, 1, 2, 0, 0));
        tbl.push_back(v(0, 0, 0, 3, 1, 2, 0, 0));
        tbl.push_back(v(0, 0, 0, 4, 1, 2, 2, 0));  // game over, team2 wins
        tbl.push_back(v(0, 0, 0, 4, 1, 2, 2, 0));
        tbl.push_back(v(0, 1, 0, 4, 1, 2, 2, 0));
        tbl.push_back(v(1, 0, 0, 1, 0, 0, 0, 1));  // restart
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 2, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 1, 0, 0, 0, 1));  // simultaneous goals -> re-serve
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 2, 0, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 2, 0, 0, 0, 0));  // start edge in play ignored
        tbl.push_back(v(0, 1, 0, 3, 1, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 3, 1, 0, 0, 0));  // start edge in pause ignored

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", dut_vec(), 16'h0000);

        foreach (tbl[i]) begin
            tick(tbl[i].s, tbl[i].g1, tbl[i].g2);
            check($sformatf("table[%0d]", i), dut_vec(), exp_of(tbl[i]));
        end

        // Two cycles into the pause with team1 on one point: reset, then release with start held.
        assert_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1, 0, 0);
            check("start_held_release", dut_vec(), 16'h0000);
        end
        tick(0, 0, 0);
        check("idle_after_release", dut_vec(), 16'h0000);
        tick(1, 0, 0);
        check("start_after_release", dut_vec(), {3'd1, 4'd0, 4'd0, 2'd0, 1'b1, 1'b0, 1'b1});

        assert_reset();
        rs = 0; rg1 = 0; rg2 = 0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                assert_reset();
            end
            if ($urandom_range(0, 7) == 0) rs = ~rs;
            if (!rg1 && !rg2 && $urandom_range(0, 39) == 0) begin
                rg1 = 1; rg2 = 1;
            end else begin
                if ($urandom_range(0, 4) == 0) rg1 = ~rg1;
                if ($urandom_range(0, 4) == 0) rg2 = ~rg2;
            end
            tick(rs, rg1, rg2);
            check("random_vs_model", dut_vec(), model_vec());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
